// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, 32-bit signed/unsigned, one quotient bit per cycle.
// Result {quotient, remainder} is registered and signalled with a one-cycle out_valid pulse.
module div_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        out_valid,
    output logic [63:0] dout
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs_mag;
    logic [31:0] dvd_raw;
    logic [4:0]  count;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic        done_q;

    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] rem_n;
    logic [31:0] quo_n;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] dvd_mag_in;
    logic [31:0] dvs_mag_in;

    assign dvd_mag_in = (signed_op && dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign dvs_mag_in = (signed_op && divisor[31])  ? (~divisor + 32'd1)  : divisor;

    // quo initially holds the dividend magnitude; its MSB feeds the remainder each step
    always_comb begin
        shifted = {rem, quo[31]};
        trial   = shifted - {1'b0, dvs_mag};
        if (!trial[32]) begin
            rem_n = trial[31:0];
            quo_n = {quo[30:0], 1'b1};
        end else begin
            rem_n = shifted[31:0];
            quo_n = {quo[30:0], 1'b0};
        end
        q_fix = div_zero ? '1      : (neg_q ? (~quo_n + 32'd1) : quo_n);
        r_fix = div_zero ? dvd_raw : (neg_r ? (~rem_n + 32'd1) : rem_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rem      <= '0;
            quo      <= '0;
            dvs_mag  <= '0;
            dvd_raw  <= '0;
            count    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
            dout     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (in_valid && !flush) begin
                        dvd_raw  <= dividend;
                        div_zero <= (divisor == 32'd0);
                        neg_q    <= signed_op && (dividend[31] ^ divisor[31]);
                        neg_r    <= signed_op && dividend[31];
                        quo      <= dvd_mag_in;
                        dvs_mag  <= dvs_mag_in;
                        rem      <= '0;
                        count    <= '0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        rem   <= rem_n;
                        quo   <= quo_n;
                        dout  <= {q_fix, r_fix};
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = done_q && !flush;

endmodule
